float_add_core: RTL and testbench

- Multi-cycle IEEE-754 single-precision add/subtract engine.
- Sits directly downstream of the float-adder AXI4-Lite register slave. That slave's operand registers A and B and its control bits drive this block. Its result/status register captures this block's output.
- Fixed-latency FSM with a valid/ready handshake on each side. Round-to-nearest-even. Subnormals are flushed to zero.

---
 rtl/float_add_core_if.sv | 28 ++
 rtl/float_add_core.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_float_add_core.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/float_add_core_if.sv
// Operand/result handshake bundle between the register slave and the float add/sub engine.
// A transfer happens on a rising edge where valid and ready are both 1; the sender holds its payload stable until then.
interface float_add_core_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_invalid;
    logic        flag_overflow;
    logic        flag_underflow;
    logic        flag_inexact;

    modport slave (
        input  in_valid, op_a, op_b, op_sub, out_ready,
        output in_ready, out_valid, result,
        output flag_invalid, flag_overflow, flag_underflow, flag_inexact
    );

    modport master (
        output in_valid, op_a, op_b, op_sub, out_ready,
        input  in_ready, out_valid, result,
        input  flag_invalid, flag_overflow, flag_underflow, flag_inexact
    );
endinterface

// File: rtl/float_add_core.sv
// Multi-cycle binary32 add/subtract: one op in flight, fixed latency, RNE rounding,
// subnormal inputs and results flushed to zero, all NaN results canonical.
module float_add_core #(
    parameter logic [31:0] CANON_NAN     = 32'h7FC00000,
    parameter bit          FTZ_SIGN_KEEP = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    float_add_core_if.slave   bus,
    output logic [2:0]        dbg_state
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        ALIGN  = 3'd2,
        ADD    = 3'd3,
        NORM   = 3'd4,
        ROUND  = 3'd5,
        HOLD   = 3'd6
    } state_t;

    state_t state;
    assign dbg_state = state;

    // Captured operands; b_q already carries the op_sub sign inversion.
    logic [31:0] a_q, b_q;

    logic        ua_s, ub_s;
    logic [7:0]  ua_e, ub_e;
    logic [23:0] ua_m, ub_m;
    logic        spec_hit, spec_inv;
    logic [31:0] spec_res;

    logic        al_s, al_sub;
    logic [7:0]  al_e;
    logic [23:0] al_mx;
    logic [26:0] al_my;

    logic        ad_s;
    logic [7:0]  ad_e;
    logic [27:0] ad_sum;

    logic              nm_s, nm_zero;
    logic signed [9:0] nm_e;
    logic [26:0]       nm_m;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) lzc27 = 5'(26 - i);
        end
    endfunction

    // UNPACK: classify operands and resolve every special-case result up front.
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic        ua_s_n, ub_s_n, spec_hit_n, spec_inv_n;
    logic [7:0]  ua_e_n, ub_e_n;
    logic [23:0] ua_m_n, ub_m_n;
    logic [31:0] spec_res_n;

    always_comb begin
        a_nan  = (&a_q[30:23]) && (|a_q[22:0]);
        b_nan  = (&b_q[30:23]) && (|b_q[22:0]);
        a_inf  = (&a_q[30:23]) && !(|a_q[22:0]);
        b_inf  = (&b_q[30:23]) && !(|b_q[22:0]);
        a_zero = (a_q[30:23] == 8'd0);
        b_zero = (b_q[30:23] == 8'd0);
        ua_s_n = a_q[31];
        ub_s_n = b_q[31];
        ua_e_n = a_q[30:23];
        ub_e_n = b_q[30:23];
        ua_m_n = a_zero ? 24'd0 : {1'b1, a_q[22:0]};
        ub_m_n = b_zero ? 24'd0 : {1'b1, b_q[22:0]};
        spec_hit_n = 1'b1;
        spec_inv_n = 1'b0;
        spec_res_n = 32'd0;
        if (a_nan || b_nan) begin
            spec_res_n = CANON_NAN;
            spec_inv_n = (a_nan && !a_q[22]) || (b_nan && !b_q[22]);
        end else if (a_inf && b_inf && (a_q[31] != b_q[31])) begin
            spec_res_n = CANON_NAN;
            spec_inv_n = 1'b1;
        end else if (a_inf) begin
            spec_res_n = a_q;
        end else if (b_inf) begin
            spec_res_n = b_q;
        end else if (a_zero && b_zero) begin
            spec_res_n = {a_q[31] & b_q[31], 31'd0};
        end else begin
            spec_hit_n = 1'b0;
        end
    end

    // ALIGN: larger magnitude becomes X; Y is shifted into a 24+3 bit field with sticky.
    logic        swap;
    logic [7:0]  x_e, y_e, diff;
    logic [23:0] x_m, y_m;
    logic [26:0] y_ext, y_field;
    logic        x_s;

    always_comb begin
        swap    = {ub_e, ub_m} > {ua_e, ua_m};
        x_s     = swap ? ub_s : ua_s;
        x_e     = swap ? ub_e : ua_e;
        x_m     = swap ? ub_m : ua_m;
        y_e     = swap ? ua_e : ub_e;
        y_m     = swap ? ua_m : ub_m;
        diff    = x_e - y_e;
        y_ext   = {y_m, 3'b000};
        y_field = 27'd0;
        if (diff >= 8'd27) begin
            y_field = {26'd0, |y_m};
        end else begin
            y_field = (y_ext >> diff) | {26'd0, |(y_ext & ((27'd1 << diff) - 27'd1))};
        end
    end

    // ADD
    logic [27:0] ad_sum_n;
    always_comb begin
        if (al_sub) ad_sum_n = {1'b0, al_mx, 3'b000} - {1'b0, al_my};
        else        ad_sum_n = {1'b0, al_mx, 3'b000} + {1'b0, al_my};
    end

    // NORM: carry-out shifts right keeping sticky, otherwise left-justify via leading-zero count.
    logic [4:0]        lz;
    logic [26:0]       nm_m_n;
    logic signed [9:0] nm_e_n;

    always_comb begin
        lz = lzc27(ad_sum[26:0]);
        if (ad_sum[27]) begin
            nm_m_n = ad_sum[27:1] | {26'd0, ad_sum[0]};
            nm_e_n = $signed({2'b00, ad_e}) + 10'sd1;
        end else begin
            nm_m_n = ad_sum[26:0] << lz;
            nm_e_n = $signed({2'b00, ad_e}) - $signed({5'd0, lz});
        end
    end

    // ROUND and final classification.
    logic              g, r, s, inc;
    logic [24:0]       m25;
    logic [23:0]       rnd_m;
    logic signed [9:0] rnd_e;
    logic [31:0]       rnd_res;
    logic              rnd_inv, rnd_ovf, rnd_unf, rnd_inx;

    always_comb begin
        g     = nm_m[2];
        r     = nm_m[1];
        s     = nm_m[0];
        inc   = g & (r | s | nm_m[3]);
        m25   = {1'b0, nm_m[26:3]} + {24'd0, inc};
        rnd_m = m25[24] ? m25[24:1] : m25[23:0];
        rnd_e = m25[24] ? (nm_e + 10'sd1) : nm_e;
        rnd_res = {nm_s, rnd_e[7:0], rnd_m[22:0]};
        rnd_inv = 1'b0;
        rnd_ovf = 1'b0;
        rnd_unf = 1'b0;
        rnd_inx = g | r | s;
        if (spec_hit) begin
            rnd_res = spec_res;
            rnd_inv = spec_inv;
            rnd_inx = 1'b0;
        end else if (nm_zero) begin
            rnd_res = 32'd0;
            rnd_inx = 1'b0;
        end else if (rnd_e >= 10'sd255) begin
            rnd_res = {nm_s, 8'hFF, 23'd0};
            rnd_ovf = 1'b1;
            rnd_inx = 1'b1;
        end else if (rnd_e <= 10'sd0) begin
            rnd_res = {(FTZ_SIGN_KEEP ? nm_s : 1'b0), 31'd0};
            rnd_unf = 1'b1;
            rnd_inx = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            bus.in_ready       <= 1'b0;
            bus.out_valid      <= 1'b0;
            bus.result         <= 32'd0;
            bus.flag_invalid   <= 1'b0;
            bus.flag_overflow  <= 1'b0;
            bus.flag_underflow <= 1'b0;
            bus.flag_inexact   <= 1'b0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            ua_s     <= 1'b0;
            ub_s     <= 1'b0;
            ua_e     <= 8'd0;
            ub_e     <= 8'd0;
            ua_m     <= 24'd0;
            ub_m     <= 24'd0;
            spec_hit <= 1'b0;
            spec_inv <= 1'b0;
            spec_res <= 32'd0;
            al_s     <= 1'b0;
            al_sub   <= 1'b0;
            al_e     <= 8'd0;
            al_mx    <= 24'd0;
            al_my    <= 27'd0;
            ad_s     <= 1'b0;
            ad_e     <= 8'd0;
            ad_sum   <= 28'd0;
            nm_s     <= 1'b0;
            nm_zero  <= 1'b0;
            nm_e     <= 10'sd0;
            nm_m     <= 27'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_ready && bus.in_valid) begin
                        a_q          <= bus.op_a;
                        b_q          <= {bus.op_b[31] ^ bus.op_sub, bus.op_b[30:0]};
                        bus.in_ready <= 1'b0;
                        state        <= UNPACK;
                    end else begin
                        bus.in_ready <= 1'b1;
                    end
                end
                UNPACK: begin
                    ua_s     <= ua_s_n;
                    ub_s     <= ub_s_n;
                    ua_e     <= ua_e_n;
                    ub_e     <= ub_e_n;
                    ua_m     <= ua_m_n;
                    ub_m     <= ub_m_n;
                    spec_hit <= spec_hit_n;
                    spec_inv <= spec_inv_n;
                    spec_res <= spec_res_n;
                    state    <= ALIGN;
                end
                ALIGN: begin
                    al_s   <= x_s;
                    al_sub <= ua_s ^ ub_s;
                    al_e   <= x_e;
                    al_mx  <= x_m;
                    al_my  <= y_field;
                    state  <= ADD;
                end
                ADD: begin
                    ad_s   <= al_s;
                    ad_e   <= al_e;
                    ad_sum <= ad_sum_n;
                    state  <= NORM;
                end
                NORM: begin
                    nm_s    <= ad_s;
                    nm_zero <= (ad_sum == 28'd0);
                    nm_e    <= nm_e_n;
                    nm_m    <= nm_m_n;
                    state   <= ROUND;
                end
                ROUND: begin
                    bus.result         <= rnd_res;
                    bus.flag_invalid   <= rnd_inv;
                    bus.flag_overflow  <= rnd_ovf;
                    bus.flag_underflow <= rnd_unf;
                    bus.flag_inexact   <= rnd_inx;
                    bus.out_valid      <= 1'b1;
                    state              <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_float_add_core.sv
// Directed bench for float_add_core: hand-computed binary32 vectors, latency, hold and reset behaviour.
module tb_float_add_core;
    logic       clock;
    logic       reset;
    logic [2:0] dbg_state;
    int         n_checks;
    int         n_errors;

    float_add_core_if bus ();

    float_add_core dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] flags();
        return {28'd0, bus.flag_invalid, bus.flag_overflow, bus.flag_underflow, bus.flag_inexact};
    endfunction

    // flags order: {invalid, overflow, underflow, inexact}
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [31:0] exp_res, input logic [3:0] exp_flags);
        int waited;
        waited = 0;
        @(negedge clock);
        while (!bus.in_ready && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        bus.op_a      = a;
        bus.op_b      = b;
        bus.op_sub    = sub;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        bus.op_a     = $urandom();
        bus.op_b     = $urandom();
        bus.op_sub   = ~sub;
        repeat (4) @(posedge clock);
        #1;
        check({tag, "_early_valid"}, {31'd0, bus.out_valid}, 32'd0);
        @(posedge clock);
        #1;
        check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, "_result"}, bus.result, exp_res);
        check({tag, "_flags"}, flags(), {28'd0, exp_flags});
        @(posedge clock);
        #1;
        check({tag, "_drop"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, "_ready_after"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        int spurious;
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op_a      = 32'd0;
        bus.op_b      = 32'd0;
        bus.op_sub    = 1'b0;

        #1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_flags", flags(), 32'd0);
        check("rst_state", {29'd0, dbg_state}, 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);

        run_op("add_1_2",     32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
        run_op("sub_cancel",  32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
        run_op("m5_p3",       32'hC0A00000, 32'h40400000, 1'b0, 32'hC0000000, 4'b0000);
        run_op("sub_1_1p5",   32'h3F800000, 32'h3FC00000, 1'b1, 32'hBF000000, 4'b0000);
        run_op("rne_tie",     32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
        run_op("rne_up",      32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001);
        run_op("overflow",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
        run_op("inf_m_inf",   32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000);
        run_op("inf_sub_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000);
        run_op("qnan",        32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000);
        run_op("snan",        32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
        run_op("ninf_fin",    32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000);
        run_op("underflow",   32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011);
        run_op("sub_in_ftz",  32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000);
        run_op("nz_nz",       32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
        run_op("pz_nz",       32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000);

        // Result held while the consumer stalls; new operands are refused.
        @(negedge clock);
        bus.op_a      = 32'h40400000;
        bus.op_b      = 32'h3F800000;
        bus.op_sub    = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
        check("hold_result", bus.result, 32'h40800000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            bus.in_valid = 1'b1;
            bus.op_a     = $urandom();
            @(posedge clock);
            #1;
            check("hold_stable_res", bus.result, 32'h40800000);
            check("hold_stable_flags", flags(), 32'd0);
            check("hold_busy", {30'd0, bus.out_valid, bus.in_ready}, 32'd2);
        end
        @(negedge clock);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        check("hold_release", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
        spurious = 0;
        repeat (8) begin
            @(posedge clock);
            #1;
            if (bus.out_valid) spurious++;
        end
        check("hold_no_queue", spurious, 32'd0);

        // Reset while the operation sits in ALIGN.
        @(negedge clock);
        bus.op_a     = 32'h3F800000;
        bus.op_b     = 32'h40000000;
        bus.op_sub   = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clock);
        #2;
        check("mid_state_align", {29'd0, dbg_state}, 32'd2);
        reset = 1'b1;
        #1;
        check("mid_rst_out", {30'd0, bus.out_valid, bus.in_ready}, 32'd0);
        check("mid_rst_state", {29'd0, dbg_state}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("mid_rel_ready", {31'd0, bus.in_ready}, 32'd1);
        spurious = 0;
        repeat (10) begin
            @(posedge clock);
            #1;
            if (bus.out_valid) spurious++;
        end
        check("mid_no_result", spurious, 32'd0);

        run_op("after_rst", 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
